// File: rtl/fifo_wr_rr_arbiter_pkg.sv
// axi_fifo_pkg: arbiter state type and the register offsets shared with the accelerator.
package axi_fifo_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  localparam logic [7:0] FIFO_WR = 8'h00;
  localparam logic [7:0] FIFO_RD = 8'h04;
  localparam logic [7:0] STATUS  = 8'h08;
endpackage

// File: rtl/fifo_wr_rr_arbiter_if.sv
// fifo_wr_rr_arbiter_if: producer handshakes plus the fifo_axi write port.
interface fifo_wr_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic                          fifo_wr_en;
  logic                          fifo_full;
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_din, fifo_wr_en
  );
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_din, fifo_wr_en
  );
endinterface

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: first valid requester at or after start, wrapping modulo NUM_REQ.
module fifo_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] start,
  output logic                       any_req,
  output logic [$clog2(NUM_REQ)-1:0] winner
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
  logic [NUM_REQ-1:0] rot;
  logic [IW:0]        sum;
  assign any_req = |req;
  // Rotate so start sits at bit 0; the lowest set bit of rot is the winner.
  always_comb begin
    rot = NUM_REQ'({req, req} >> start);
    sum = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      sum = rot[i] ? {1'b0, start} + (IW+1)'(i) : sum;
    winner = sum >= NR ? IW'(sum - NR) : IW'(sum);
  end
endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// fifo_wr_rr_arbiter: round-robin, burst-locked sharing of one fifo_axi write port
// with per-requester accepted-beat counters.
module fifo_wr_rr_arbiter
  import axi_fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  fifo_wr_rr_arbiter_if.slave            bus,
  input  logic                           cnt_clr,
  output logic                           grant_active,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic [NUM_REQ*CNT_WIDTH-1:0]   beat_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  arb_state_t                         state_q, state_d;
  logic [IW-1:0]                      grant_id_q, grant_id_d, ptr_q, ptr_d, winner;
  logic [BW-1:0]                      burst_q, burst_d;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]              data_a [NUM_REQ];
  logic                               any_req, acc, done;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
    assign data_a[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.req_valid),
    .start   (ptr_q),
    .any_req (any_req),
    .winner  (winner)
  );
  // Write path is purely combinational from the registered grant, so a held grant costs no latency.
  assign acc            = state_q == ARB_GRANT && bus.req_valid[grant_id_q] && !bus.fifo_full;
  assign bus.req_ready  = acc ? NUM_REQ'(1) << grant_id_q : '0;
  assign bus.fifo_wr_en = acc;
  assign bus.fifo_din   = data_a[grant_id_q];
  assign grant_active   = state_q == ARB_GRANT;
  assign grant_id       = grant_id_q;
  assign beat_cnt       = cnt_q;
  assign done = !bus.req_valid[grant_id_q] ||
                (acc && (bus.req_last[grant_id_q] || burst_q == BW'(BURST_MAX - 1)));
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    if (state_q == ARB_IDLE) begin
      if (any_req) begin
        state_d    = ARB_GRANT;
        grant_id_d = winner;
        burst_d    = '0;
      end
    end else if (done) begin
      state_d = ARB_IDLE;
      ptr_d   = grant_id_q == IW'(NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
    end else if (acc) begin
      burst_d = burst_q + 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++)
      cnt_d[i] = (cnt_clr ? '0 : cnt_q[i]) + CNT_WIDTH'(bus.req_ready[i]);
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      ptr_q      <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// tb_fifo_wr_rr_arbiter: directed scenarios against a grant/queue model of the arbiter,
// checked every cycle, plus literal expectations for grant order and write data.
module tb_fifo_wr_rr_arbiter;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int BM   = 4;
  localparam int CW   = 8;
  localparam int CMOD = 1 << CW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cnt_clr = 1'b0;
  logic            grant_active;
  logic [1:0]      grant_id;
  logic [N*CW-1:0] beat_cnt;
  int              tests = 0;
  int              fails = 0;

  always #5 clk = ~clk;

  fifo_wr_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  // Narrow counters keep the wrap scenario short.
  fifo_wr_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM), .CNT_WIDTH(CW)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .bus           (bus.slave),
    .cnt_clr       (cnt_clr),
    .grant_active  (grant_active),
    .grant_id      (grant_id),
    .beat_cnt      (beat_cnt)
  );

  // Model: holder (-1 when idle), next scan start, beats in current grant, counters.
  int m_hold, m_next, m_beats, m_win;
  int m_cnt [N];
  logic m_acc;

  always_comb begin
    m_acc = m_hold >= 0 && bus.req_valid[m_hold] && !bus.fifo_full;
    m_win = -1;
    for (int k = 0; k < N; k++)
      if (m_win < 0 && bus.req_valid[(m_next + k) % N]) m_win = (m_next + k) % N;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold  <= -1;
      m_next  <= 0;
      m_beats <= 0;
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++)
        m_cnt[i] <= ((cnt_clr ? 0 : m_cnt[i]) + ((m_acc && m_hold == i) ? 1 : 0)) % CMOD;
      if (m_hold < 0) begin
        if (m_win >= 0) begin
          m_hold  <= m_win;
          m_beats <= 0;
        end
      end else if (!bus.req_valid[m_hold] ||
                   (m_acc && (bus.req_last[m_hold] || m_beats + 1 == BM))) begin
        m_hold <= -1;
        m_next <= (m_hold + 1) % N;
      end else if (m_acc) begin
        m_beats <= m_beats + 1;
      end
    end
  end

  // Observation logs for literal checks.
  int          glog [$];
  logic [31:0] wlog [$];
  logic        prev_act = 1'b0;

  task automatic compare_cycle();
    logic [N-1:0] er;
    logic         ok;
    er = m_acc ? N'(1) << m_hold : '0;
    ok = (grant_active === (m_hold >= 0)) && (bus.req_ready === er) && (bus.fifo_wr_en === m_acc);
    if (m_hold >= 0) ok = ok && (grant_id === 2'(m_hold));
    if (m_acc) ok = ok && (bus.fifo_din === bus.req_data[m_hold*DW +: DW]);
    for (int i = 0; i < N; i++) ok = ok && (beat_cnt[i*CW +: CW] === CW'(m_cnt[i]));
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL cycle@%0t: act=%b id=%0d rdy=%b wr=%b din=%h cnt=%h | exp hold=%0d rdy=%b wr=%b cnt=%0h/%0h/%0h/%0h",
               $time, grant_active, grant_id, bus.req_ready, bus.fifo_wr_en, bus.fifo_din, beat_cnt,
               m_hold, er, m_acc, m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]);
    end
    if (grant_active === 1'b1 && !prev_act) glog.push_back(int'(grant_id));
    prev_act = grant_active === 1'b1;
    if (bus.fifo_wr_en === 1'b1) wlog.push_back(bus.fifo_din);
  endtask

  always @(negedge clk) compare_cycle();

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Producers: per-requester beat queues {last, data}; head is presented while non-empty.
  logic [DW:0]  pq [N][$];
  logic [N-1:0] rdy_s;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]          = pq[i].size() > 0;
      bus.req_last[i]           = pq[i].size() > 0 ? pq[i][0][DW] : 1'b0;
      bus.req_data[i*DW +: DW]  = pq[i].size() > 0 ? pq[i][0][DW-1:0] : '0;
    end
  endtask

  task automatic half1();
    @(negedge clk);
    rdy_s = bus.req_ready;
  endtask

  task automatic half2();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rdy_s[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    drive();
  endtask

  task automatic drain(string name);
    int n = 0;
    do begin
      half1();
      half2();
      n++;
    end while (n < 2000 && (pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() > 0 || grant_active));
    check({name, "_drain_bound"}, 64'(n < 2000), 64'd1);
  endtask

  task automatic wait_ready(int i, string name);
    int n = 0;
    half1();
    while (!rdy_s[i] && n < 50) begin
      half2();
      half1();
      n++;
    end
    check(name, 64'(rdy_s[i]), 64'd1);
  endtask

  int          base_g, base_w;
  int          exp_rr [5] = '{0, 1, 2, 3, 0};
  logic [31:0] exp_bl [7] = '{32'h110, 32'h111, 32'h112, 32'h113, 32'h120, 32'h114, 32'h115};
  logic [31:0] exp_bp [3] = '{32'hA0, 32'hA1, 32'hA2};

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.fifo_full = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_active", 64'(grant_active), 64'd0);
    check("rst_id", 64'(grant_id), 64'd0);
    check("rst_cnt", 64'(beat_cnt), 64'd0);

    // Round-robin fairness with single-beat bursts.
    base_g = glog.size();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 2; b++) pq[i].push_back({1'b1, 32'(32'h10 * i + b)});
    drive();
    drain("rr");
    check("rr_ngrants", 64'(glog.size() - base_g), 64'd8);
    for (int k = 0; k < 5; k++) check("rr_order", 64'(glog[base_g + k]), 64'(exp_rr[k]));
    for (int i = 0; i < N; i++) check("rr_cnt", 64'(beat_cnt[i*CW +: CW]), 64'd2);

    // Burst lock: req1 cut at BURST_MAX, req2 served, req1 resumes.
    base_w = wlog.size();
    for (int b = 0; b < 6; b++) pq[1].push_back({b == 5, 32'(32'h110 + b)});
    pq[2].push_back({1'b1, 32'h120});
    drive();
    drain("bl");
    check("bl_nwrites", 64'(wlog.size() - base_w), 64'd7);
    for (int k = 0; k < 7; k++) check("bl_data", 64'(wlog[base_w + k]), 64'(exp_bl[k]));

    // Full back-pressure mid-burst of req0.
    base_w = wlog.size();
    for (int b = 0; b < 3; b++) pq[0].push_back({b == 2, 32'(32'hA0 + b)});
    drive();
    wait_ready(0, "bp_start");
    half2();
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      half1();
      check("bp_hold", {grant_active, grant_id, bus.fifo_wr_en, bus.req_ready}, {1'b1, 2'd0, 1'b0, 4'b0});
      half2();
    end
    bus.fifo_full = 1'b0;
    drain("bp");
    for (int k = 0; k < 3; k++) check("bp_data", 64'(wlog[base_w + k]), 64'(exp_bp[k]));

    // Yield after one beat with a coinciding counter clear.
    pq[3].push_back({1'b0, 32'h30});
    drive();
    wait_ready(3, "y_start");
    cnt_clr = 1'b1;
    half2();
    cnt_clr = 1'b0;
    check("clr_cnt", 64'(beat_cnt), 64'({8'd1, 8'd0, 8'd0, 8'd0}));
    half1();
    half2();
    check("yield_idle", 64'(grant_active), 64'd0);

    // Counter wrap on req0.
    for (int b = 0; b < 255; b++) pq[0].push_back({1'b0, 32'(b)});
    drive();
    drain("wrap_a");
    check("wrap_ff", 64'(beat_cnt[0 +: CW]), 64'hFF);
    pq[0].push_back({1'b1, 32'hFF});
    drive();
    drain("wrap_b");
    check("wrap_00", 64'(beat_cnt[0 +: CW]), 64'h00);
    check("wrap_cnt3", 64'(beat_cnt[3*CW +: CW]), 64'h01);

    // Reset asserted mid-burst.
    for (int b = 0; b < 4; b++) pq[0].push_back({1'b0, 32'(32'hB0 + b)});
    drive();
    wait_ready(0, "rst_start");
    half2();
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_active", 64'(grant_active), 64'd0);
    check("rstmid_wr", 64'(bus.fifo_wr_en), 64'd0);
    check("rstmid_cnt", 64'(beat_cnt), 64'd0);
    for (int i = 0; i < N; i++) pq[i].delete();
    drive();
    repeat (2) begin
      half1();
      half2();
    end
    rst_n = 1'b1;
    base_g = glog.size();
    pq[2].push_back({1'b1, 32'hC2});
    pq[1].push_back({1'b1, 32'hC1});
    drive();
    drain("post_rst");
    check("post_rst_first", 64'(glog[base_g]), 64'd1);
    check("post_rst_second", 64'(glog[base_g + 1]), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
